// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
//  Shared definitions for the PWM ramp controller: halfword register offsets,
//  CTRL bit positions, the controller state type and a byte-enable merge
//  helper used by every shadow register write.
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

   // Halfword register offsets on the 16-bit register bus
   localparam logic [3:0] ADDR_PER_LO = 4'h0;
   localparam logic [3:0] ADDR_PER_HI = 4'h2;
   localparam logic [3:0] ADDR_T0_LO  = 4'h4;
   localparam logic [3:0] ADDR_T0_HI  = 4'h6;
   localparam logic [3:0] ADDR_T1_LO  = 4'h8;
   localparam logic [3:0] ADDR_T1_HI  = 4'hA;
   localparam logic [3:0] ADDR_CTRL   = 4'hC;
   localparam logic [3:0] ADDR_RAMP   = 4'hE;

   // CTRL register bit positions
   localparam int CTRL_ENA     = 0;
   localparam int CTRL_INV     = 1;
   localparam int CTRL_RAMP_EN = 2;
   localparam int CTRL_APPLY   = 3;
   localparam int CTRL_BUSY    = 4;
   localparam int CTRL_PEND    = 5;

   // Controller state; a pending commit is a separate flag that overlays
   // RUN or RAMP rather than a state of its own
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RAMP = 2'd2
   } state_t;

   // Replace only the byte lanes whose enable is set
   function automatic logic [15:0] merge_bytes(
      input logic [15:0] old_val,
      input logic [15:0] new_val,
      input logic [1:0]  lanes
   );
      logic [15:0] result;
      result = old_val;
      if (lanes[0]) result[7:0]  = new_val[7:0];
      if (lanes[1]) result[15:8] = new_val[15:8];
      return result;
   endfunction

endpackage

// File: rtl/pwm_ramp_step.sv
// -----------------------------------------------------------------------------
// pwm_ramp_step
//  Combinational saturating slew of a 32-bit value toward a target by at most
//  step per call. Never overshoots the target and never wraps around zero or
//  the top of the 32-bit range.
// Ports:
//  cur     in  32  present value
//  tgt     in  32  value being slewed toward
//  step    in  8   maximum change per call
//  next    out 32  value after one slew step
//  at_tgt  out 1   next equals tgt
// -----------------------------------------------------------------------------
module pwm_ramp_step (
   input  logic [31:0] cur,
   input  logic [31:0] tgt,
   input  logic [7:0]  step,
   output logic [31:0] next,
   output logic        at_tgt
);

   logic [32:0] dist_up;
   logic [32:0] dist_dn;
   logic [32:0] step_ext;

   // Distances are formed at 33 bits so the comparison against step can
   // never be fooled by a 32-bit wrap
   assign dist_up  = {1'b0, tgt} - {1'b0, cur};
   assign dist_dn  = {1'b0, cur} - {1'b0, tgt};
   assign step_ext = {25'd0, step};

   // Land exactly on the target whenever the remaining distance fits in one step
   always_comb begin
      next = cur;
      if (tgt > cur) begin
         if (dist_up <= step_ext) next = tgt;
         else                     next = cur + {24'd0, step};
      end else if (cur > tgt) begin
         if (dist_dn <= step_ext) next = tgt;
         else                     next = cur - {24'd0, step};
      end
   end

   assign at_tgt = (next == tgt);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//  Bus-programmed controller for one 32-bit PWM core. Period, compare 0,
//  compare 1 target and invert are written into shadow registers and only
//  committed to the core at a period boundary, or at once while the core is
//  stopped. Compare 1 (duty) can be slewed linearly toward its target.
// Ports:
//  clk      in   1         system clock
//  sclr     in   1         synchronous reset, active-high
//  addr     in   4         halfword register address
//  be       in   2         byte enables for wrdata[7:0] / wrdata[15:8]
//  write    in   1         write strobe
//  wrdata   in   16        write data
//  rddata   out  16        read data, combinational from addr
//  per_end  in   1         last-clock-of-period pulse from the core
//  pwm_per  out  32        active period
//  pwm_t    out  [1:0][31:0] active compares, t[1] is the ramped duty
//  pwm_ena  out  1         core enable
//  pwm_inv  out  1         output invert
//  busy     out  1         ramp in progress or commit pending
//  done     out  1         one-clock pulse when a ramp reaches its target
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             sclr,
   input  logic [3:0]       addr,
   input  logic [1:0]       be,
   input  logic             write,
   input  logic [15:0]      wrdata,
   output logic [15:0]      rddata,
   input  logic             per_end,
   output logic [31:0]      pwm_per,
   output logic [1:0][31:0] pwm_t,
   output logic             pwm_ena,
   output logic             pwm_inv,
   output logic             busy,
   output logic             done
);

   // Shadow registers, visible on the bus but not yet driving the core
   logic [31:0] per_sh;
   logic [31:0] t0_sh;
   logic [31:0] t1_sh;
   logic        inv_sh;
   logic        ramp_en;
   logic [7:0]  step;
   logic [7:0]  div;

   // Ramp bookkeeping
   state_t      state;
   logic        pending;
   logic [31:0] ramp_tgt;
   logic [7:0]  divcnt;

   // Decoded write and next-state helpers
   logic        ctrl_wr;
   logic        ena_next;
   logic        ramp_en_next;
   logic        apply;
   logic        commit_edge;
   logic        commit_jump;
   logic        ramp_tick;
   logic [31:0] slew_next;
   logic        slew_at_tgt;

   pwm_ramp_step u_step (
      .cur    (pwm_t[1]),
      .tgt    (ramp_tgt),
      .step   (step),
      .next   (slew_next),
      .at_tgt (slew_at_tgt)
   );

   // A CTRL write takes effect on its own edge, so the fields written
   // alongside apply (ena, inv, ramp_en) are the ones the commit uses.
   // A pending commit only fires on a per_end strictly after the apply edge,
   // which falls out naturally because pending is still 0 on the apply edge.
   // Clearing ena aborts a pending commit on that same edge.
   always_comb begin
      ctrl_wr      = write && (addr == ADDR_CTRL) && be[0];
      ena_next     = ctrl_wr ? wrdata[CTRL_ENA]     : pwm_ena;
      ramp_en_next = ctrl_wr ? wrdata[CTRL_RAMP_EN] : ramp_en;
      apply        = ctrl_wr && wrdata[CTRL_APPLY];
      commit_edge  = (apply && !pwm_ena) ||
                     (ena_next && pending && per_end && pwm_ena);
      commit_jump  = !ena_next || !ramp_en_next || (step == 8'd0) ||
                     (t1_sh == pwm_t[1]);
      ramp_tick    = ena_next && pwm_ena && per_end && (state == RAMP) &&
                     (divcnt == div);
   end

   // Bus-side shadow registers; byte lanes are honoured on every write
   always_ff @(posedge clk) begin
      if (sclr) begin
         per_sh  <= '0;
         t0_sh   <= '0;
         t1_sh   <= '0;
         inv_sh  <= 1'b0;
         ramp_en <= 1'b0;
         step    <= '0;
         div     <= '0;
      end else if (write) begin
         case (addr)
            ADDR_PER_LO: per_sh[15:0]  <= merge_bytes(per_sh[15:0],  wrdata, be);
            ADDR_PER_HI: per_sh[31:16] <= merge_bytes(per_sh[31:16], wrdata, be);
            ADDR_T0_LO:  t0_sh[15:0]   <= merge_bytes(t0_sh[15:0],   wrdata, be);
            ADDR_T0_HI:  t0_sh[31:16]  <= merge_bytes(t0_sh[31:16],  wrdata, be);
            ADDR_T1_LO:  t1_sh[15:0]   <= merge_bytes(t1_sh[15:0],   wrdata, be);
            ADDR_T1_HI:  t1_sh[31:16]  <= merge_bytes(t1_sh[31:16],  wrdata, be);
            ADDR_CTRL: begin
               if (be[0]) begin
                  inv_sh  <= wrdata[CTRL_INV];
                  ramp_en <= wrdata[CTRL_RAMP_EN];
               end
            end
            ADDR_RAMP: begin
               if (be[0]) step <= wrdata[7:0];
               if (be[1]) div  <= wrdata[15:8];
            end
            default: ;
         endcase
      end
   end

   // Active outputs to the core. Commit copies the shadows; between commits
   // only the ramp moves pwm_t[1]. Disabling freezes everything in place.
   always_ff @(posedge clk) begin
      if (sclr) begin
         pwm_per  <= '0;
         pwm_t    <= '0;
         pwm_inv  <= 1'b0;
         pwm_ena  <= 1'b0;
         ramp_tgt <= '0;
      end else begin
         pwm_ena <= ena_next;
         if (commit_edge) begin
            pwm_per  <= per_sh;
            pwm_t[0] <= t0_sh;
            pwm_inv  <= ctrl_wr ? wrdata[CTRL_INV] : inv_sh;
            ramp_tgt <= t1_sh;
            if (commit_jump) pwm_t[1] <= t1_sh;
         end else if (ramp_tick) begin
            pwm_t[1] <= slew_next;
         end
      end
   end

   // Controller FSM: state, pending flag, period divider and done pulse.
   // A commit always restarts the divider, and from RAMP it restarts the
   // slew from wherever pwm_t[1] currently sits.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state   <= IDLE;
         pending <= 1'b0;
         divcnt  <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!ena_next) begin
            state   <= IDLE;
            pending <= 1'b0;
            divcnt  <= '0;
         end else if (commit_edge) begin
            pending <= 1'b0;
            divcnt  <= '0;
            state   <= commit_jump ? RUN : RAMP;
         end else begin
            if (apply) pending <= 1'b1;
            if (state == IDLE) begin
               state <= RUN;
            end else if (pwm_ena && per_end && (state == RAMP)) begin
               if (divcnt == div) begin
                  divcnt <= '0;
                  if (slew_at_tgt) begin
                     state <= RUN;
                     done  <= 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 8'd1;
               end
            end
         end
      end
   end

   assign busy = (state == RAMP) || pending;

   // Register read mux; compare 1 reads back the live duty, not the target
   always_comb begin
      rddata = '0;
      case (addr)
         ADDR_PER_LO: rddata = per_sh[15:0];
         ADDR_PER_HI: rddata = per_sh[31:16];
         ADDR_T0_LO:  rddata = t0_sh[15:0];
         ADDR_T0_HI:  rddata = t0_sh[31:16];
         ADDR_T1_LO:  rddata = pwm_t[1][15:0];
         ADDR_T1_HI:  rddata = pwm_t[1][31:16];
         ADDR_CTRL:   rddata = {10'd0, pending, busy, 1'b0, ramp_en, inv_sh, pwm_ena};
         ADDR_RAMP:   rddata = {div, step};
         default:     rddata = '0;
      endcase
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//  Directed bench for pwm_ramp_ctrl: register writes, shadow/commit timing,
//  linear ramp up and down, apply/per_end collisions, disable and reset.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

   logic             clk;
   logic             sclr;
   logic [3:0]       addr;
   logic [1:0]       be;
   logic             write;
   logic [15:0]      wrdata;
   logic [15:0]      rddata;
   logic             per_end;
   logic [31:0]      pwm_per;
   logic [1:0][31:0] pwm_t;
   logic             pwm_ena;
   logic             pwm_inv;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   pwm_ramp_ctrl dut (
      .clk     (clk),
      .sclr    (sclr),
      .addr    (addr),
      .be      (be),
      .write   (write),
      .wrdata  (wrdata),
      .rddata  (rddata),
      .per_end (per_end),
      .pwm_per (pwm_per),
      .pwm_t   (pwm_t),
      .pwm_ena (pwm_ena),
      .pwm_inv (pwm_inv),
      .busy    (busy),
      .done    (done)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle 1 ns past the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-clock bus write
   task automatic apply_stimulus(input logic [3:0] a, input logic [15:0] d,
                                 input logic [1:0] b);
      addr   = a;
      wrdata = d;
      be     = b;
      write  = 1'b1;
      tick();
      write  = 1'b0;
   endtask

   // One-clock period-end pulse from the core
   task automatic pulse_per_end();
      per_end = 1'b1;
      tick();
      per_end = 1'b0;
   endtask

   // Combinational register read
   task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
      addr = a;
      #1;
      v = rddata;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] rv;
      int          exp_t1   [8];
      int          exp_done [8];

      exp_t1   = '{0, 100, 100, 200, 200, 300, 300, 350};
      exp_done = '{0, 0, 0, 0, 0, 0, 0, 1};

      sclr    = 1'b1;
      addr    = 4'h0;
      be      = 2'b00;
      write   = 1'b0;
      wrdata  = 16'h0000;
      per_end = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      check_output("rst_per",  pwm_per,           32'd0);
      check_output("rst_t1",   pwm_t[1],          32'd0);
      check_output("rst_ena",  32'(pwm_ena),      32'd0);
      check_output("rst_busy", 32'(busy),         32'd0);
      check_output("rst_done", 32'(done),         32'd0);
      sclr = 1'b0;
      tick();

      // ---- test 1: program and enable with apply, commit on the write edge ----
      apply_stimulus(4'h0, 16'd1000, 2'b11);
      apply_stimulus(4'h2, 16'd0,    2'b11);
      apply_stimulus(4'h4, 16'h0123, 2'b11);
      apply_stimulus(4'h6, 16'd0,    2'b11);
      apply_stimulus(4'h8, 16'd250,  2'b11);
      apply_stimulus(4'hA, 16'd0,    2'b11);
      apply_stimulus(4'hC, 16'h0009, 2'b11);
      check_output("t1_per",  pwm_per,      32'd1000);
      check_output("t1_t0",   pwm_t[0],     32'h123);
      check_output("t1_t1",   pwm_t[1],     32'd250);
      check_output("t1_ena",  32'(pwm_ena), 32'd1);
      check_output("t1_busy", 32'(busy),    32'd0);
      read_reg(4'h8, rv);
      check_output("t1_rd_t1", 32'(rv), 32'd250);

      // Byte-lane write touches only the shadow's high byte
      apply_stimulus(4'h0, 16'hAB00, 2'b10);
      read_reg(4'h0, rv);
      check_output("be_rd_per", 32'(rv), 32'hABE8);
      check_output("be_active_per", pwm_per, 32'd1000);
      read_reg(4'h1, rv);
      check_output("rd_unmapped", 32'(rv), 32'd0);
      apply_stimulus(4'h0, 16'd1000, 2'b11);

      // ---- test 2: running apply waits for per_end ----
      apply_stimulus(4'h8, 16'd400,  2'b11);
      apply_stimulus(4'hC, 16'h000B, 2'b11);
      check_output("t2_t1_hold", pwm_t[1],  32'd250);
      check_output("t2_busy",    32'(busy), 32'd1);
      read_reg(4'hC, rv);
      check_output("t2_rd_ctrl", 32'(rv), 32'h33);
      tick(); tick(); tick(); tick();
      check_output("t2_t1_wait", pwm_t[1],     32'd250);
      check_output("t2_inv_old", 32'(pwm_inv), 32'd0);
      pulse_per_end();
      check_output("t2_t1_new",  pwm_t[1],     32'd400);
      check_output("t2_inv_new", 32'(pwm_inv), 32'd1);
      check_output("t2_busy_off", 32'(busy),   32'd0);

      // ---- test 3: ramp 0 -> 350, STEP=100, DIV=1 ----
      apply_stimulus(4'hE, 16'h0164, 2'b11);
      apply_stimulus(4'h8, 16'd0,    2'b11);
      apply_stimulus(4'hC, 16'h0009, 2'b11);
      pulse_per_end();
      check_output("t3_t1_zero", pwm_t[1], 32'd0);
      apply_stimulus(4'h8, 16'd350,  2'b11);
      apply_stimulus(4'hC, 16'h000D, 2'b11);
      pulse_per_end();
      check_output("t3_commit_t1",   pwm_t[1],  32'd0);
      check_output("t3_commit_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         pulse_per_end();
         check_output($sformatf("t3_t1_%0d", i),   pwm_t[1],  32'(exp_t1[i]));
         check_output($sformatf("t3_done_%0d", i), 32'(done), 32'(exp_done[i]));
      end
      tick();
      check_output("t3_done_clear", 32'(done), 32'd0);
      check_output("t3_busy_clear", 32'(busy), 32'd0);

      // ---- test 4: ramp down 350 -> 0, STEP=200, DIV=0 ----
      apply_stimulus(4'hE, 16'h00C8, 2'b11);
      apply_stimulus(4'h8, 16'd0,    2'b11);
      apply_stimulus(4'hC, 16'h000D, 2'b11);
      pulse_per_end();
      check_output("t4_commit_t1", pwm_t[1], 32'd350);
      pulse_per_end();
      check_output("t4_step1", pwm_t[1], 32'd150);
      pulse_per_end();
      check_output("t4_step2", pwm_t[1],  32'd0);
      check_output("t4_done",  32'(done), 32'd1);

      // ---- test 5: apply colliding with per_end, then mid-ramp retarget ----
      apply_stimulus(4'hE, 16'h0064, 2'b11);
      apply_stimulus(4'h8, 16'd300,  2'b11);
      per_end = 1'b1;
      apply_stimulus(4'hC, 16'h000D, 2'b11);
      per_end = 1'b0;
      check_output("t5_same_edge_t1",   pwm_t[1],  32'd0);
      check_output("t5_same_edge_busy", 32'(busy), 32'd1);
      pulse_per_end();
      check_output("t5_commit_t1", pwm_t[1], 32'd0);
      pulse_per_end();
      check_output("t5_step1", pwm_t[1], 32'd100);
      apply_stimulus(4'h8, 16'd50,   2'b11);
      apply_stimulus(4'hC, 16'h000D, 2'b11);
      check_output("t5_pend_t1", pwm_t[1], 32'd100);
      pulse_per_end();
      check_output("t5_restart_t1",   pwm_t[1],  32'd100);
      check_output("t5_restart_done", 32'(done), 32'd0);
      pulse_per_end();
      check_output("t5_down_t1",   pwm_t[1],  32'd50);
      check_output("t5_down_done", 32'(done), 32'd1);

      // ---- test 6: disable mid-ramp, then reset mid-pending ----
      apply_stimulus(4'h8, 16'd400,  2'b11);
      apply_stimulus(4'hC, 16'h000D, 2'b11);
      pulse_per_end();
      pulse_per_end();
      check_output("t6_ramp_t1", pwm_t[1], 32'd150);
      apply_stimulus(4'hC, 16'h0000, 2'b11);
      check_output("t6_ena_off",  32'(pwm_ena), 32'd0);
      check_output("t6_busy_off", 32'(busy),    32'd0);
      pulse_per_end();
      check_output("t6_t1_frozen", pwm_t[1], 32'd150);
      apply_stimulus(4'hC, 16'h0001, 2'b11);
      apply_stimulus(4'h0, 16'd77,   2'b11);
      apply_stimulus(4'hC, 16'h0009, 2'b11);
      check_output("t6_pending", 32'(busy), 32'd1);
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      check_output("t6_rst_per",  pwm_per,      32'd0);
      check_output("t6_rst_t1",   pwm_t[1],     32'd0);
      check_output("t6_rst_ena",  32'(pwm_ena), 32'd0);
      check_output("t6_rst_busy", 32'(busy),    32'd0);
      pulse_per_end();
      check_output("t6_no_commit_per", pwm_per,   32'd0);
      check_output("t6_no_done",       32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
